// File: rtl/div_operand_fixup.sv
// Signed/unsigned operand fixup around an unsigned pipelined divider for RV32IM DIV/DIVU/REM/REMU.
// Per-op metadata rides a shift pipeline in lockstep with the divider; results get sign/divide-by-zero correction.
module div_operand_fixup #(
   parameter int LATENCY = 8,
   parameter int XLEN    = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            i_valid,
   input  logic [1:0]      i_op,
   input  logic [4:0]      i_rd,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   output logic [XLEN-1:0] o_div_dividend,
   output logic [XLEN-1:0] o_div_divisor,
   input  logic [XLEN-1:0] i_div_quotient,
   input  logic [XLEN-1:0] i_div_remainder,
   output logic            o_valid,
   output logic [4:0]      o_rd,
   output logic [XLEN-1:0] o_result,
   output logic            o_busy,
   input  logic [4:0]      i_chk_rs1,
   input  logic [4:0]      i_chk_rs2,
   output logic            o_hazard
);

   localparam int LAST = LATENCY - 1;

   function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
      return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
   endfunction

   function automatic logic [XLEN-1:0] fix_result(
      input logic            is_rem,
      input logic            dz,
      input logic            negq,
      input logic            negr,
      input logic [XLEN-1:0] rs1,
      input logic [XLEN-1:0] q,
      input logic [XLEN-1:0] r
   );
      if (dz) return is_rem ? rs1 : '1;
      return is_rem ? neg_if(negr, r) : neg_if(negq, q);
   endfunction

   logic is_signed, neg1, neg2, dz;

   always_comb begin
      is_signed = ~i_op[0];
      neg1      = is_signed & i_rs1[XLEN-1];
      neg2      = is_signed & i_rs2[XLEN-1];
      dz        = (i_rs2 == '0);
   end

   // Divider sees magnitudes every cycle; 0x80000000 stays put and reads as 2^31.
   assign o_div_dividend = neg_if(neg1, i_rs1);
   assign o_div_divisor  = neg_if(neg2, i_rs2);

   logic [LATENCY-1:0] vld_q, vld_d;
   logic [LATENCY-1:0] is_rem_q, is_rem_d;
   logic [LATENCY-1:0] dz_q, dz_d;
   logic [LATENCY-1:0] negq_q, negq_d;
   logic [LATENCY-1:0] negr_q, negr_d;
   logic [4:0]         rd_q  [LATENCY];
   logic [4:0]         rd_d  [LATENCY];
   logic [XLEN-1:0]    rs1_q [LATENCY];
   logic [XLEN-1:0]    rs1_d [LATENCY];

   always_comb begin
      vld_d    = vld_q;
      is_rem_d = is_rem_q;
      dz_d     = dz_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      rd_d     = rd_q;
      rs1_d    = rs1_q;
      if (!stall) begin
         vld_d[0]    = i_valid;
         is_rem_d[0] = i_op[1];
         dz_d[0]     = dz;
         negq_d[0]   = is_signed & (neg1 ^ neg2) & ~dz;
         negr_d[0]   = neg1 & ~dz;
         rd_d[0]     = i_rd;
         rs1_d[0]    = i_rs1;
         for (int k = 1; k < LATENCY; k++) begin
            vld_d[k]    = vld_q[k-1];
            is_rem_d[k] = is_rem_q[k-1];
            dz_d[k]     = dz_q[k-1];
            negq_d[k]   = negq_q[k-1];
            negr_d[k]   = negr_q[k-1];
            rd_d[k]     = rd_q[k-1];
            rs1_d[k]    = rs1_q[k-1];
         end
      end
   end

   // Only the valid bits need reset; payload is qualified by them everywhere.
   always_ff @(posedge clk) begin
      if (rst) vld_q <= '0;
      else     vld_q <= vld_d;
   end

   always_ff @(posedge clk) begin
      is_rem_q <= is_rem_d;
      dz_q     <= dz_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
   end

   logic [XLEN-1:0] result;

   always_comb begin
      result   = fix_result(is_rem_q[LAST], dz_q[LAST], negq_q[LAST], negr_q[LAST],
                            rs1_q[LAST], i_div_quotient, i_div_remainder);
      o_valid  = vld_q[LAST];
      o_rd     = vld_q[LAST] ? rd_q[LAST] : 5'd0;
      o_result = vld_q[LAST] ? result : '0;
      o_busy   = |vld_q;
      o_hazard = 1'b0;
      // x0 is never a real dependency.
      for (int k = 0; k < LATENCY; k++) begin
         if (vld_q[k] && (rd_q[k] != 5'd0) &&
             ((rd_q[k] == i_chk_rs1) || (rd_q[k] == i_chk_rs2)))
            o_hazard = 1'b1;
      end
   end

endmodule

// File: tb/tb_div_operand_fixup.sv
// Bench for div_operand_fixup: a behavioural unsigned divider feeds the DUT, and an
// op-list reference model predicts results from RISC-V divide semantics.
module tb_div_operand_fixup;

   localparam int LATENCY = 8;
   localparam int XLEN    = 32;
   localparam int MAXOPS  = 1024;

   logic        clk = 1'b0;
   logic        rst, stall, i_valid;
   logic [1:0]  i_op;
   logic [4:0]  i_rd, i_chk_rs1, i_chk_rs2, o_rd;
   logic [31:0] i_rs1, i_rs2, o_div_dividend, o_div_divisor;
   logic [31:0] i_div_quotient, i_div_remainder, o_result;
   logic        o_valid, o_busy, o_hazard;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   div_operand_fixup #(.LATENCY(LATENCY), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .stall(stall), .i_valid(i_valid), .i_op(i_op), .i_rd(i_rd),
      .i_rs1(i_rs1), .i_rs2(i_rs2), .o_div_dividend(o_div_dividend), .o_div_divisor(o_div_divisor),
      .i_div_quotient(i_div_quotient), .i_div_remainder(i_div_remainder),
      .o_valid(o_valid), .o_rd(o_rd), .o_result(o_result), .o_busy(o_busy),
      .i_chk_rs1(i_chk_rs1), .i_chk_rs2(i_chk_rs2), .o_hazard(o_hazard)
   );

   // Behavioural 8-stage unsigned divider sharing the stall.
   logic [31:0] dq [LATENCY];
   logic [31:0] dr [LATENCY];
   always @(posedge clk) begin
      if (!stall) begin
         dq[0] <= (o_div_divisor == 0) ? 32'hFFFFFFFF : o_div_dividend / o_div_divisor;
         dr[0] <= (o_div_divisor == 0) ? o_div_dividend : o_div_dividend % o_div_divisor;
         for (int k = 1; k < LATENCY; k++) begin
            dq[k] <= dq[k-1];
            dr[k] <= dr[k-1];
         end
      end
   end
   assign i_div_quotient  = dq[LATENCY-1];
   assign i_div_remainder = dr[LATENCY-1];

   // Reference model: list of accepted ops, each tagged with the unstalled edge it entered on.
   int          n_edges = 0;
   int          nops    = 0;
   int          base    = 0;
   int          op_a  [MAXOPS];
   logic [1:0]  op_op [MAXOPS];
   logic [4:0]  op_rd [MAXOPS];
   logic [31:0] op_r1 [MAXOPS];
   logic [31:0] op_r2 [MAXOPS];

   always @(posedge clk) begin
      if (rst) begin
         base <= nops;
      end else if (!stall) begin
         n_edges <= n_edges + 1;
         if (i_valid && nops < MAXOPS) begin
            op_a[nops]  <= n_edges + 1;
            op_op[nops] <= i_op;
            op_rd[nops] <= i_rd;
            op_r1[nops] <= i_rs1;
            op_r2[nops] <= i_rs2;
            nops        <= nops + 1;
         end
      end
   end

   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic signed [31:0] sa, sb;
      logic               ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
      if (b == 0) return op[1] ? a : 32'hFFFFFFFF;
      case (op)
         2'b00:   return ovf ? a : $unsigned(sa / sb);
         2'b01:   return a / b;
         2'b10:   return ovf ? 32'h0 : $unsigned(sa % sb);
         default: return a % b;
      endcase
   endfunction

   function automatic void model(output logic ev, output logic [4:0] erd, output logic [31:0] eres,
                                 output logic ebusy, output logic ehaz);
      ev = 0; erd = 0; eres = 0; ebusy = 0; ehaz = 0;
      for (int i = base; i < nops; i++) begin
         if (op_a[i] + LATENCY - 1 >= n_edges) begin
            ebusy = 1;
            if (op_rd[i] != 0 && (op_rd[i] == i_chk_rs1 || op_rd[i] == i_chk_rs2)) ehaz = 1;
         end
         if (op_a[i] + LATENCY - 1 == n_edges) begin
            ev   = 1;
            erd  = op_rd[i];
            eres = ref_result(op_op[i], op_r1[i], op_r2[i]);
         end
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b);
      i_valid = v; i_op = op; i_rd = rd; i_rs1 = a; i_rs2 = b;
   endtask

   task automatic idle(input int n);
      rst = 0; stall = 0; i_valid = 0;
      repeat (n) step();
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFFFFFF;
         3:       return 32'h80000000;
         4:       return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset();
      rst = 1; stall = 0; i_chk_rs1 = 0; i_chk_rs2 = 0;
      drive(1'b0, 2'd0, 5'd0, 32'd0, 32'd0);
      step(); step();
      rst = 0;
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
      checks++; if (o_hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard: got %b expected 0", o_hazard); end
      checks++; if (o_rd !== 5'd0) begin failures++; $display("FAIL reset_rd: got %0d expected 0", o_rd); end
      checks++; if (o_result !== 32'd0) begin failures++; $display("FAIL reset_result: got %h expected 0", o_result); end
   endtask

   task automatic test_operand_prep();
      logic [1:0]  t_op [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [31:0] t_a  [5] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'h80000000, 32'h5};
      logic [31:0] t_b  [5] = '{32'h2, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};
      logic [31:0] e_a  [5] = '{32'h7, 32'hFFFFFFF9, 32'h80000000, 32'h80000000, 32'h5};
      logic [31:0] e_b  [5] = '{32'h2, 32'h2, 32'h1, 32'hFFFFFFFF, 32'h5};
      idle(2);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, t_op[i], 5'd0, t_a[i], t_b[i]);
         #1;
         checks++; if (o_div_dividend !== e_a[i]) begin failures++; $display("FAIL prep_dividend[%0d]: got %h expected %h", i, o_div_dividend, e_a[i]); end
         checks++; if (o_div_divisor !== e_b[i]) begin failures++; $display("FAIL prep_divisor[%0d]: got %h expected %h", i, o_div_divisor, e_b[i]); end
      end
   endtask

   task automatic test_spec_vectors();
      localparam int N = 9;
      logic [1:0]  t_op [N] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd2, 2'd0, 2'd0, 2'd2, 2'd1};
      logic [4:0]  t_rd [N] = '{5'd5, 5'd6, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9, 5'd10};
      logic [31:0] t_a  [N] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h12345678, 32'h5, 32'hFFFFFFFB,
                                32'h7, 32'h80000000, 32'h80000000, 32'h80000000};
      logic [31:0] t_b  [N] = '{32'h2, 32'h2, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] t_e  [N] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'hFFFFFFFB,
                                32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h0};
      idle(10);
      for (int c = 0; c <= N + 7; c++) begin
         if (c < N) drive(1'b1, t_op[c], t_rd[c], t_a[c], t_b[c]);
         else       i_valid = 0;
         step();
         if (c == 6 || c == N + 7) begin
            checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL vec_idle_valid c=%0d: got %b expected 0", c, o_valid); end
         end else if (c >= 7) begin
            checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL vec_valid[%0d]: got %b expected 1", c - 7, o_valid); end
            checks++; if (o_rd !== t_rd[c-7]) begin failures++; $display("FAIL vec_rd[%0d]: got %0d expected %0d", c - 7, o_rd, t_rd[c-7]); end
            checks++; if (o_result !== t_e[c-7]) begin failures++; $display("FAIL vec_result[%0d]: got %h expected %h", c - 7, o_result, t_e[c-7]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      localparam int N = 8;
      idle(10);
      for (int c = 0; c <= N + 7; c++) begin
         if (c < N) drive(1'b1, 2'd1, 5'(c + 1), 32'd100, 32'(c + 1));
         else       i_valid = 0;
         step();
         if (c >= 7 && c - 7 < N) begin
            checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d]: got %b expected 1", c - 7, o_valid); end
            checks++; if (o_rd !== 5'(c - 6)) begin failures++; $display("FAIL b2b_rd[%0d]: got %0d expected %0d", c - 7, o_rd, c - 6); end
            checks++; if (o_result !== 32'(100 / (c - 6))) begin failures++; $display("FAIL b2b_result[%0d]: got %0d expected %0d", c - 7, o_result, 100 / (c - 6)); end
            checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy[%0d]: got %b expected 1", c - 7, o_busy); end
         end
         if (c == N + 7) begin
            checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_fall: got %b expected 0", o_busy); end
            checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_end: got %b expected 0", o_valid); end
         end
      end
   endtask

   task automatic test_stall();
      logic        ev;
      logic [4:0]  erd;
      logic [31:0] eres;
      idle(10);
      for (int c = 0; c <= 16; c++) begin
         stall = (c >= 3 && c <= 5) || c == 11 || c == 12;
         if (c == 0)                drive(1'b1, 2'd0, 5'd3, 32'hFFFFFF9C, 32'd7);
         else if (c == 1)           drive(1'b1, 2'd2, 5'd4, 32'hFFFFFF9C, 32'd7);
         else if (c >= 3 && c <= 5) drive(1'b1, 2'd1, 5'd9, $urandom, 32'd3);
         else                       i_valid = 0;
         step();
         ev   = (c >= 10 && c <= 13);
         erd  = (c >= 10 && c <= 12) ? 5'd3 : (c == 13) ? 5'd4 : 5'd0;
         eres = (c >= 10 && c <= 12) ? 32'hFFFFFFF2 : (c == 13) ? 32'hFFFFFFFE : 32'h0;
         checks++; if (o_valid !== ev) begin failures++; $display("FAIL stall_valid c=%0d: got %b expected %b", c, o_valid, ev); end
         checks++; if (o_rd !== erd) begin failures++; $display("FAIL stall_rd c=%0d: got %0d expected %0d", c, o_rd, erd); end
         checks++; if (o_result !== eres) begin failures++; $display("FAIL stall_result c=%0d: got %h expected %h", c, o_result, eres); end
      end
      stall = 0;
   endtask

   task automatic test_hazard();
      logic eh;
      idle(10);
      for (int c = 0; c <= 9; c++) begin
         if (c == 0) drive(1'b1, 2'd1, 5'd7, 32'd50, 32'd5);
         else        i_valid = 0;
         step();
         i_chk_rs1 = (c % 2 == 0) ? 5'd7 : 5'd0;
         i_chk_rs2 = (c % 2 == 0) ? 5'd0 : 5'd7;
         if (c == 4) begin i_chk_rs1 = 5'd8; i_chk_rs2 = 5'd6; end
         #1;
         eh = (c <= 7) && (c != 4);
         checks++; if (o_hazard !== eh) begin failures++; $display("FAIL hazard_rd7 c=%0d: got %b expected %b", c, o_hazard, eh); end
      end
      i_chk_rs1 = 0; i_chk_rs2 = 0;
      for (int c = 0; c <= 3; c++) begin
         if (c == 0) drive(1'b1, 2'd0, 5'd0, 32'd9, 32'd3);
         else        i_valid = 0;
         step();
         checks++; if (o_hazard !== 1'b0) begin failures++; $display("FAIL hazard_x0 c=%0d: got %b expected 0", c, o_hazard); end
         checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL hazard_x0_busy c=%0d: got %b expected 1", c, o_busy); end
      end
   endtask

   task automatic test_reset_midflight();
      idle(10);
      i_chk_rs1 = 5'd7; i_chk_rs2 = 5'd0;
      drive(1'b1, 2'd1, 5'd7, 32'd77, 32'd7);
      step();
      i_valid = 0;
      repeat (3) step();
      rst = 1;
      step();
      rst = 0;
      checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b expected 0", o_valid); end
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", o_busy); end
      checks++; if (o_hazard !== 1'b0) begin failures++; $display("FAIL midrst_hazard: got %b expected 0", o_hazard); end
      for (int c = 0; c < 10; c++) begin
         step();
         checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL midrst_ghost c=%0d: got %b expected 0", c, o_valid); end
      end
   endtask

   task automatic test_random();
      logic        ev, eb, eh;
      logic [4:0]  erd;
      logic [31:0] eres;
      idle(10);
      for (int c = 0; c < 400; c++) begin
         rst       = ($urandom_range(0, 99) == 0);
         stall     = ($urandom_range(0, 4) == 0);
         drive($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
               pick_operand(), pick_operand());
         i_chk_rs1 = 5'($urandom_range(0, 7));
         i_chk_rs2 = 5'($urandom_range(0, 31));
         step();
         model(ev, erd, eres, eb, eh);
         checks++; if (o_valid !== ev) begin failures++; $display("FAIL rand_valid c=%0d: got %b expected %b", c, o_valid, ev); end
         checks++; if (o_rd !== erd) begin failures++; $display("FAIL rand_rd c=%0d: got %0d expected %0d", c, o_rd, erd); end
         checks++; if (o_result !== eres) begin failures++; $display("FAIL rand_result c=%0d: got %h expected %h", c, o_result, eres); end
         checks++; if (o_busy !== eb) begin failures++; $display("FAIL rand_busy c=%0d: got %b expected %b", c, o_busy, eb); end
         checks++; if (o_hazard !== eh) begin failures++; $display("FAIL rand_hazard c=%0d: got %b expected %b", c, o_hazard, eh); end
      end
      idle(10);
   endtask

   initial begin
      rst = 1; stall = 0; i_valid = 0; i_op = 0; i_rd = 0; i_rs1 = 0; i_rs2 = 0;
      i_chk_rs1 = 0; i_chk_rs2 = 0;
      test_reset();
      test_operand_prep();
      test_spec_vectors();
      test_back_to_back();
      test_stall();
      test_hazard();
      test_reset_midflight();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div_operand_fixup.md
Name: div_operand_fixup

Overview:
- Wrapper control stage around the 8-stage unsigned pipelined divider in the RV32IM execute path.
- Upstream side: converts DIV/DIVU/REM/REMU operands to unsigned magnitudes and drives them into the divider.
- Downstream side: carries per-op metadata through an 8-deep shift pipeline in lockstep with the divider, then applies sign correction and RISC-V divide-by-zero rules to the divider's quotient/remainder.
- Also reports in-flight destination registers to the hazard unit.

Parameters:
- LATENCY, 8, divider register depth in stages; must equal the divider's stage count.
- XLEN, 32, operand width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- stall  in  1  global pipeline stall; shared with the divider's stall.
- i_valid  in  1  divide op presented this cycle.
- i_op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- i_rd  in  5  destination register.
- i_rs1  in  XLEN  dividend operand.
- i_rs2  in  XLEN  divisor operand.
- o_div_dividend  out  XLEN  to divider i_dividend.
- o_div_divisor  out  XLEN  to divider i_divisor.
- i_div_quotient  in  XLEN  from divider o_quotient.
- i_div_remainder  in  XLEN  from divider o_remainder.
- o_valid  out  1  result valid this cycle.
- o_rd  out  5  destination of o_result.
- o_result  out  XLEN  final architectural result.
- o_busy  out  1  any op in flight.
- i_chk_rs1  in  5  source register 1 of the decode-stage instruction.
- i_chk_rs2  in  5  source register 2 of the decode-stage instruction.
- o_hazard  out  1  a checked source matches an in-flight rd.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset clears all LATENCY metadata valid bits.
  - Next cycle: o_valid=0, o_busy=0, o_hazard=0.
  - o_rd and o_result read 0 while their stage is invalid.
  - Reset mid-flight discards all ops; no result is ever produced for them.
- Operand prep (combinational):
  - signed = ~i_op[0]; neg1 = signed & i_rs1[31]; neg2 = signed & i_rs2[31].
  - o_div_dividend = neg1 ? -i_rs1 : i_rs1, 2's complement, truncated to XLEN. 0x80000000 maps to 0x80000000, read as unsigned 2^31.
  - o_div_divisor: same rule with neg2 and i_rs2.
  - Outputs are driven regardless of i_valid; the divider computes every cycle.
- Metadata per stage:
  - valid, rd, is_rem (i_op[1]), dz (i_rs2==0), negq (signed & (neg1^neg2) & ~dz), negr (neg1 & ~dz), rs1 original value.
  - Stage 0 loads {i_valid & ~stall, ...} at the clock edge when ~stall.
  - Stage k loads stage k-1 when ~stall.
  - When stall=1, every stage holds, including valid bits. i_valid is ignored while stalled; upstream must hold the op.
- Latency: an op accepted at edge t appears at the output after edge t+LATENCY-1 (8 edges total, unstalled), aligned with the divider outputs. Each stall cycle adds exactly 1.
- Result (combinational from the last stage and divider outputs):
  - dz & ~is_rem: o_result = 0xFFFFFFFF (DIV and DIVU).
  - dz & is_rem: o_result = original rs1 (REM and REMU).
  - ~is_rem: o_result = negq ? -i_div_quotient : i_div_quotient.
  - is_rem: o_result = negr ? -i_div_remainder : i_div_remainder.
  - Overflow case DIV 0x80000000 / -1 needs no special path: it yields 0x80000000, and REM yields 0.
- Outputs:
  - o_valid = last-stage valid; o_rd = last-stage rd.
  - Under stall, o_valid/o_rd/o_result stay constant. The consumer samples one result per unstalled cycle.
  - Throughput: one op per unstalled cycle; back-to-back ops retire in order, one per cycle.
- Tracking:
  - o_busy = OR of all stage valid bits.
  - o_hazard = 1 if any valid stage, last stage included, has rd != 0 and rd equal to i_chk_rs1 or i_chk_rs2.
  - rd = x0 never raises a hazard.

Test Plan:
- DIV rs1=0xFFFFFFF9 (-7), rs2=2, rd=5, no stall: after 8 edges o_valid=1, o_rd=5, o_result=0xFFFFFFFD. The same operands with REM give 0xFFFFFFFF.
- Divide-by-zero: DIVU 0x12345678/0 gives 0xFFFFFFFF; REMU 5/0 gives 5; REM 0xFFFFFFFB/0 gives 0xFFFFFFFB; DIV 7/0 gives 0xFFFFFFFF.
- Overflow: DIV 0x80000000/0xFFFFFFFF gives 0x80000000. REM with the same operands gives 0. DIVU with the same operands gives 0.
- 8 back-to-back ops, rd=1..8, each 100/k: o_valid high for 8 consecutive cycles, o_rd=1..8 in order, results 100/k. o_busy falls the cycle after the last retires.
- stall=1 for 3 cycles while 2 ops are in flight: o_valid/o_result frozen during the stall, and each result arrives exactly 3 cycles later than unstalled.
- Op with rd=7 in flight, i_chk_rs1=7 → o_hazard=1; an op with rd=0 and i_chk_rs1=0 → o_hazard=0. Asserting rst at cycle 4 of a flight → o_valid, o_busy, o_hazard all 0 the next cycle, and no result ever appears.
